// File: rtl/heat_pkg.sv
// rtl/heat_pkg.sv - shared 5.27 fixed-point constants, FSM state and pixel entry types for the heat frame reader
package heat_pkg;

    localparam int FP_WIDTH     = 32;
    localparam int FP_FRAC_BITS = 27;

    localparam logic signed [FP_WIDTH-1:0] FP_SRC = 32'sh4000_0000;
    localparam logic signed [FP_WIDTH-1:0] FP_SNK = 32'shC000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] x;
        logic [7:0] y;
    } pix_t;

endpackage

// File: rtl/heat_color_map.sv
// rtl/heat_color_map.sv - combinational 5.27 node value to RGB332 color; HEAT_SINK_MARK_EN marks source/sink nodes
module heat_color_map
    import heat_pkg::*;
(
    input  logic signed [FP_WIDTH-1:0] i_q,
    output logic        [7:0]          o_rgb
);

    // -8.0 .. +8.0 spans the 0..255 index range: offset by +8.0, keep 8 integer-ish bits
    localparam logic signed [FP_WIDTH:0] W_OFFSET = 33'sd1 <<< (FP_FRAC_BITS + 3);
    localparam int                       W_SHIFT  = FP_FRAC_BITS - 4;

    logic signed [FP_WIDTH:0] w_sum;
    logic signed [FP_WIDTH:0] w_shift;
    logic        [7:0]        w_idx;
    logic        [7:0]        w_rgb;

    assign w_sum   = {i_q[FP_WIDTH-1], i_q} + W_OFFSET;
    assign w_shift = w_sum >>> W_SHIFT;

    always_comb begin
        w_idx = w_shift[7:0];
        if (w_shift[FP_WIDTH]) begin
            w_idx = 8'h00;
        end else if (|w_shift[FP_WIDTH-1:8]) begin
            w_idx = 8'hFF;
        end
    end

    assign w_rgb = {w_idx[7:5], w_idx[4:2], ~w_idx[7:6]};

`ifdef HEAT_SINK_MARK_EN
    always_comb begin
        o_rgb = w_rgb;
        if (i_q == FP_SRC) begin
            o_rgb = 8'hFF;
        end else if (i_q == FP_SNK) begin
            o_rgb = 8'h03;
        end
    end
`else
    assign o_rgb = w_rgb;
`endif

endmodule

// File: rtl/heat_frame_reader.sv
// rtl/heat_frame_reader.sv - scans N_COLS x N_ROWS M10K node values into an RGB332 pixel stream
// Optional HEAT_SINK_MARK_EN (in heat_color_map) forces source/sink node colors.
module heat_frame_reader
    import heat_pkg::*;
#(
    parameter int N_ROWS = 256,
    parameter int N_COLS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic [7:0]  rd_col,
    output logic [7:0]  rd_addr,
    input  logic [31:0] rd_q,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_data,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        frame_done
);

    localparam logic [7:0] L_LAST_ROW = 8'(N_ROWS - 1);
    localparam logic [7:0] L_LAST_COL = 8'(N_COLS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_col;
    logic [7:0] r_addr;
    logic       r_inf_v;
    logic [7:0] r_inf_x;
    logic [7:0] r_inf_y;
    logic [1:0] r_cnt;
    pix_t       r_head;
    pix_t       r_tail;
    pix_t       w_new;
    logic [7:0] w_color;
    logic [2:0] w_level;
    logic       w_room;
    logic       w_issue;
    logic       w_pop;
    logic       w_last_addr;
    logic       w_last_pix;

    heat_color_map u_color_map (
        .i_q   (rd_q),
        .o_rgb (w_color)
    );

    assign rd_col      = r_col;
    assign rd_addr     = r_addr;
    assign pix_valid   = (r_cnt != 2'd0);
    assign pix_data    = r_head.data;
    assign pix_x       = r_head.x;
    assign pix_y       = r_head.y;
    assign w_pop       = pix_valid && pix_ready;
    assign w_new       = '{data: w_color, x: r_inf_x, y: r_inf_y};
    assign w_last_addr = (r_col == L_LAST_COL) && (r_addr == L_LAST_ROW);
    assign w_last_pix  = (r_head.x == L_LAST_COL) && (r_head.y == L_LAST_ROW);

    // Issue only if the buffer can still absorb this read one cycle after the in-flight one lands
    assign w_level = {1'b0, r_cnt} + {2'b00, r_inf_v} - {2'b00, w_pop};
    assign w_room  = (w_level <= 3'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_last_addr ? DRAIN : SCAN;
            SCAN:    if (w_issue && w_last_addr) w_next = DRAIN;
            DRAIN:   if (frame_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Address 0 is already presented in IDLE, so the start cycle itself issues the first read
    always_comb begin
        busy       = 1'b0;
        w_issue    = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            IDLE:  w_issue = start;
            SCAN: begin
                busy    = 1'b1;
                w_issue = w_room;
            end
            DRAIN: begin
                busy       = 1'b1;
                frame_done = w_pop && w_last_pix;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col   <= 8'd0;
            r_addr  <= 8'd0;
            r_inf_v <= 1'b0;
            r_inf_x <= 8'd0;
            r_inf_y <= 8'd0;
        end else begin
            r_inf_v <= w_issue;
            if (w_issue) begin
                r_inf_x <= r_col;
                r_inf_y <= r_addr;
                if (r_addr == L_LAST_ROW) begin
                    r_addr <= 8'd0;
                    r_col  <= (r_col == L_LAST_COL) ? 8'd0 : r_col + 8'd1;
                end else begin
                    r_addr <= r_addr + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({r_inf_v, w_pop})
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= w_new;
                    end else begin
                        r_head <= w_new;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= w_new;
                    end else begin
                        r_tail <= w_new;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_heat_frame_reader.sv
// tb/tb_heat_frame_reader.sv - directed self-checking bench for heat_frame_reader (4 rows x 2 columns)
module tb_heat_frame_reader;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 2;
    localparam int N_PIX  = N_ROWS * N_COLS;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic [7:0]  rd_col;
    logic [7:0]  rd_addr;
    logic [31:0] rd_q;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic        frame_done;

    int          n_tests;
    int          n_fail;
    int          q_mode;
    logic [31:0] const_q;
    logic [7:0]  ramp_tab [N_PIX];

    heat_frame_reader #(
        .N_ROWS (N_ROWS),
        .N_COLS (N_COLS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .rd_col     (rd_col),
        .rd_addr    (rd_addr),
        .rd_q       (rd_q),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Node k = x*N_ROWS + y holds a value whose color index is k*36
    function automatic logic [31:0] model_q(input logic [7:0] c, input logic [7:0] a);
        int k;
        if (q_mode != 0) return const_q;
        k = (int'(c) * N_ROWS + int'(a)) * 36;
        return 32'(k << 23) - 32'h4000_0000;
    endfunction

    always @(posedge clk) rd_q <= model_q(rd_col, rd_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_col", {24'd0, rd_col}, 32'd0);
        check("rst_addr", {24'd0, rd_addr}, 32'd0);
        check("rst_data", {24'd0, pix_data}, 32'd0);
        check("rst_x", {24'd0, pix_x}, 32'd0);
        check("rst_y", {24'd0, pix_y}, 32'd0);
    endtask

    // rmode 0: ready always 1; rmode 1: random ready. Stops after stop_n pixels are sampled for acceptance.
    task automatic run_frame(input int rmode, input int stop_n, input bit spam_start, input logic [7:0] cexp);
        int         n;
        int         cyc;
        bit         stalled;
        logic [7:0] hd;
        logic [7:0] hx;
        logic [7:0] hy;
        logic [7:0] exp_d;
        n = 0;
        cyc = 0;
        stalled = 1'b0;
        hd = 8'd0;
        hx = 8'd0;
        hy = 8'd0;
        @(negedge clk);
        start = 1'b1;
        pix_ready = (rmode == 0);
        @(negedge clk);
        start = spam_start;
        #1;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("no_early_valid", {31'd0, pix_valid}, 32'd0);
        while (n < stop_n && cyc < 500) begin
            @(negedge clk);
            pix_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            start = spam_start;
            #1;
            if (rmode == 0) check("stream_valid", {31'd0, pix_valid}, 32'd1);
            if (stalled) begin
                check("stall_valid", {31'd0, pix_valid}, 32'd1);
                check("stall_data", {24'd0, pix_data}, {24'd0, hd});
                check("stall_x", {24'd0, pix_x}, {24'd0, hx});
                check("stall_y", {24'd0, pix_y}, {24'd0, hy});
            end
            stalled = 1'b0;
            if (pix_valid && pix_ready) begin
                exp_d = (q_mode == 0) ? ramp_tab[n] : cexp;
                check("pix_x", {24'd0, pix_x}, 32'(n / N_ROWS));
                check("pix_y", {24'd0, pix_y}, 32'(n % N_ROWS));
                check("pix_data", {24'd0, pix_data}, {24'd0, exp_d});
                check("frame_done_at_accept", {31'd0, frame_done}, {31'd0, (n == N_PIX - 1)});
                n++;
            end else begin
                check("frame_done_quiet", {31'd0, frame_done}, 32'd0);
                if (pix_valid) begin
                    stalled = 1'b1;
                    hd = pix_data;
                    hx = pix_x;
                    hy = pix_y;
                end
            end
            cyc++;
        end
        if (n < stop_n) check("frame_timeout", 32'(n), 32'(stop_n));
        if (stop_n == N_PIX) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check("busy_after_frame", {31'd0, busy}, 32'd0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                #1;
                check("idle_no_valid", {31'd0, pix_valid}, 32'd0);
                check("idle_no_busy", {31'd0, busy}, 32'd0);
                check("idle_no_done", {31'd0, frame_done}, 32'd0);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        q_mode = 0;
        const_q = 32'd0;
        ramp_tab = '{8'h03, 8'h27, 8'h4A, 8'h6E, 8'h91, 8'hB5, 8'hD8, 8'hFC};
        reset_n = 1'b0;
        start = 1'b0;
        pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        reset_n = 1'b1;

        // Full-rate ramp frame, then a stalled ramp frame
        run_frame(0, N_PIX, 1'b0, 8'h00);
        run_frame(1, N_PIX, 1'b0, 8'h00);

        // Reset asserted between cycles while the 5th pixel is on the bus
        run_frame(0, 5, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        run_frame(1, N_PIX, 1'b0, 8'h00);

        // start held high throughout, including the final acceptance
        run_frame(1, N_PIX, 1'b1, 8'h00);

        q_mode = 1;
        const_q = 32'h0000_0000;
        run_frame(0, N_PIX, 1'b0, 8'h81);
        const_q = 32'h3FFF_FFFF;
        run_frame(0, N_PIX, 1'b0, 8'hFC);
        const_q = 32'hB800_0000;
        run_frame(0, N_PIX, 1'b0, 8'h03);
        const_q = 32'h4000_0000;
`ifdef HEAT_SINK_MARK_EN
        run_frame(0, N_PIX, 1'b0, 8'hFF);
`else
        run_frame(0, N_PIX, 1'b0, 8'hFC);
`endif
        const_q = 32'hC000_0000;
        run_frame(1, N_PIX, 1'b0, 8'h03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
